fc_layer_sequencer: RTL and testbench

Sequencer for the fully-connected layer datapath. It walks all output-neuron groups (LANES neurons in parallel) and all input elements, and issues activation and weight read addresses. It drives the datapath valid/first/last strobes and tracks the datapath pipeline latency so it can raise a writeback strobe per finished group. A single start pulse runs one full FC layer. A done pulse is raised after the last group drains.

---
 rtl/fc_pkg.sv | 16 +
 rtl/valid_delay_line.sv | 26 ++
 rtl/fc_layer_sequencer.sv | 133 +++++++++++++
 tb/tb_fc_layer_sequencer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
// rtl/fc_pkg.sv - shared FSM state encoding and default sizes for the FC layer sequencer
package fc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fc_state_t;

  localparam int FC_N_IN     = 512;
  localparam int FC_N_OUT    = 64;
  localparam int FC_LANES    = 8;
  localparam int FC_PIPE_LAT = 8;

endpackage

// File: rtl/valid_delay_line.sv
// rtl/valid_delay_line.sv - DEPTH-stage 1-bit shift register with asynchronous clear
module valid_delay_line #(
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr <= '0;
    end else begin
      sr[0] <= din;
      for (int k = 1; k < DEPTH; k++) begin
        sr[k] <= sr[k-1];
      end
    end
  end

  assign dout = sr[DEPTH-1];

endmodule

// File: rtl/fc_layer_sequencer.sv
// rtl/fc_layer_sequencer.sv - FC layer address/strobe sequencer; FC_SEQ_PERF_EN adds stall_cnt
module fc_layer_sequencer
  import fc_pkg::*;
#(
  parameter int N_IN     = FC_N_IN,
  parameter int N_OUT    = FC_N_OUT,
  parameter int LANES    = FC_LANES,
  parameter int PIPE_LAT = FC_PIPE_LAT,
  parameter int AW_IN    = (N_IN > 1) ? $clog2(N_IN) : 1,
  parameter int AW_W     = ((N_IN * N_OUT / LANES) > 1) ? $clog2(N_IN * N_OUT / LANES) : 1,
  parameter int GW       = ((N_OUT / LANES) > 1) ? $clog2(N_OUT / LANES) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mem_ready,
  output logic             busy,
  output logic             done,
  output logic [AW_IN-1:0] act_addr,
  output logic [AW_W-1:0]  w_addr,
  output logic             dp_valid,
  output logic             dp_first,
  output logic             dp_last,
  output logic             wb_en,
  output logic [GW-1:0]    wb_group
`ifdef FC_SEQ_PERF_EN
  ,
  output logic [31:0]      stall_cnt
`endif
);

  localparam int G = N_OUT / LANES;
  localparam logic [AW_IN-1:0] I_LAST = AW_IN'(N_IN - 1);
  localparam logic [GW-1:0]    G_LAST = GW'(G - 1);

  generate
    if (N_OUT % LANES != 0) begin : g_bad_lanes
      $error("fc_layer_sequencer: N_OUT must be a multiple of LANES");
    end
    if (PIPE_LAT < 1) begin : g_bad_lat
      $error("fc_layer_sequencer: PIPE_LAT must be at least 1");
    end
  endgenerate

  fc_state_t        state, state_nxt;
  logic [AW_IN-1:0] i_cnt;
  logic [GW-1:0]    g_cnt;
  logic             start_ok;
  logic             elem_last;
  logic             issue_final;

  assign start_ok    = (state == IDLE) && start;
  assign elem_last   = (i_cnt == I_LAST);
  assign issue_final = dp_valid && elem_last && (g_cnt == G_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    dp_valid  = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = RUN;
      RUN: begin
        busy     = 1'b1;
        dp_valid = mem_ready;
        if (mem_ready && elem_last && (g_cnt == G_LAST)) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (wb_en && (wb_group == G_LAST)) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign dp_first = dp_valid && (i_cnt == '0);
  assign dp_last  = dp_valid && elem_last;
  assign act_addr = i_cnt;

  // Counters return to zero after the final issue so an idle block shows clean addresses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_cnt  <= '0;
      g_cnt  <= '0;
      w_addr <= '0;
    end else if (start_ok || issue_final) begin
      i_cnt  <= '0;
      g_cnt  <= '0;
      w_addr <= '0;
    end else if (dp_valid) begin
      w_addr <= w_addr + AW_W'(1);
      if (elem_last) begin
        i_cnt <= '0;
        g_cnt <= g_cnt + GW'(1);
      end else begin
        i_cnt <= i_cnt + AW_IN'(1);
      end
    end
  end

  valid_delay_line #(
    .DEPTH(PIPE_LAT)
  ) u_wb_delay (
    .clk (clk),
    .rst (rst),
    .din (dp_last),
    .dout(wb_en)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                wb_group <= '0;
    else if (start_ok)      wb_group <= '0;
    else if (wb_en)         wb_group <= (wb_group == G_LAST) ? '0 : wb_group + GW'(1);
  end

`ifdef FC_SEQ_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                                 stall_cnt <= '0;
    else if (start_ok)                                       stall_cnt <= '0;
    else if (state == RUN && !mem_ready && stall_cnt != '1)  stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// tb/tb_fc_layer_sequencer.sv - scoreboard bench for fc_layer_sequencer (N_IN=4, N_OUT=16, LANES=8, PIPE_LAT=8)
module tb_fc_layer_sequencer;

  localparam int N_IN     = 4;
  localparam int N_OUT    = 16;
  localparam int LANES    = 8;
  localparam int PIPE_LAT = 8;
  localparam int G        = N_OUT / LANES;
  localparam int TOTAL    = G * N_IN;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       mem_ready = 1'b0;
  logic       busy, done, dp_valid, dp_first, dp_last, wb_en;
  logic [1:0] act_addr;
  logic [2:0] w_addr;
  logic [0:0] wb_group;
`ifdef FC_SEQ_PERF_EN
  logic [31:0] stall_cnt;
`endif

  fc_layer_sequencer #(
    .N_IN(N_IN), .N_OUT(N_OUT), .LANES(LANES), .PIPE_LAT(PIPE_LAT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .mem_ready(mem_ready),
    .busy(busy), .done(done), .act_addr(act_addr), .w_addr(w_addr),
    .dp_valid(dp_valid), .dp_first(dp_first), .dp_last(dp_last),
    .wb_en(wb_en), .wb_group(wb_group)
`ifdef FC_SEQ_PERF_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; int act; int w; bit first; bit last; } iss_t;
  typedef struct { int cyc; int grp; } wb_t;
  typedef enum { M_IDLE, M_RUN, M_DRAIN } mode_t;

  iss_t  iss_q[$];
  wb_t   wb_q[$];
  int    vectors = 0;
  int    miscompares = 0;
  bit    exp_busy = 1'b0;
  bit    exp_done = 1'b0;
  mode_t m_mode = M_IDLE;
  int    m_k = 0;
  int    m_done_cyc = 0;
  int    m_stall = 0;

  // Reference: drives one cycle of inputs and pushes what that cycle must produce.
  task automatic drive_cycle(input bit st, input bit rdy, input bit rs);
    int c;
    bit was_idle;
    @(posedge clk);
    #1;
    c = cyc;
    start = st; mem_ready = rdy; rst = rs;
    exp_busy = 1'b0; exp_done = 1'b0;
    if (rs) begin
      iss_q.delete(); wb_q.delete();
      m_mode = M_IDLE; m_stall = 0;
      return;
    end
    was_idle = (m_mode == M_IDLE);
    if (m_mode == M_RUN) begin
      exp_busy = 1'b1;
      if (rdy) begin
        iss_q.push_back('{c, m_k % N_IN, m_k, (m_k % N_IN) == 0, (m_k % N_IN) == N_IN - 1});
        if (m_k % N_IN == N_IN - 1) wb_q.push_back('{c + PIPE_LAT, m_k / N_IN});
        if (m_k == TOTAL - 1) begin
          m_mode = M_DRAIN;
          m_done_cyc = c + PIPE_LAT + 1;
        end
        m_k++;
      end else begin
        m_stall++;
      end
    end else if (m_mode == M_DRAIN) begin
      if (c == m_done_cyc) begin
        exp_done = 1'b1;
        m_mode = M_IDLE;
      end else begin
        exp_busy = 1'b1;
      end
    end
    if (was_idle && st) begin
      m_mode = M_RUN; m_k = 0; m_stall = 0;
    end
  endtask

  always @(negedge clk) begin : monitor
    iss_t e;
    wb_t  b;
    vectors++;
    if (dp_valid) begin
      if (iss_q.size() == 0) begin
        miscompares++;
        $display("FAIL issue_unexpected cyc=%0d got dp_valid=1 exp dp_valid=0", cyc);
      end else begin
        e = iss_q.pop_front();
        if (e.cyc != cyc || int'(act_addr) != e.act || int'(w_addr) != e.w ||
            dp_first !== e.first || dp_last !== e.last) begin
          miscompares++;
          $display("FAIL issue cyc=%0d got act=%0d w=%0d first=%0b last=%0b exp cyc=%0d act=%0d w=%0d first=%0b last=%0b",
                   cyc, act_addr, w_addr, dp_first, dp_last, e.cyc, e.act, e.w, e.first, e.last);
        end
      end
    end else begin
      if ((iss_q.size() > 0 && iss_q[0].cyc <= cyc) || dp_first !== 1'b0 || dp_last !== 1'b0) begin
        miscompares++;
        $display("FAIL issue_missing cyc=%0d got valid=%0b first=%0b last=%0b exp an issue or quiet strobes",
                 cyc, dp_valid, dp_first, dp_last);
        if (iss_q.size() > 0 && iss_q[0].cyc <= cyc) e = iss_q.pop_front();
      end
    end
    vectors++;
    if (wb_en) begin
      if (wb_q.size() == 0) begin
        miscompares++;
        $display("FAIL wb_unexpected cyc=%0d got wb_en=1 group=%0d exp wb_en=0", cyc, wb_group);
      end else begin
        b = wb_q.pop_front();
        if (b.cyc != cyc || int'(wb_group) != b.grp) begin
          miscompares++;
          $display("FAIL wb cyc=%0d got group=%0d exp cyc=%0d group=%0d", cyc, wb_group, b.cyc, b.grp);
        end
      end
    end else if (wb_q.size() > 0 && wb_q[0].cyc <= cyc) begin
      b = wb_q.pop_front();
      miscompares++;
      $display("FAIL wb_missing cyc=%0d got wb_en=0 exp wb_en=1 group=%0d", cyc, b.grp);
    end
    vectors++;
    if (busy !== exp_busy || done !== exp_done) begin
      miscompares++;
      $display("FAIL busy_done cyc=%0d got busy=%0b done=%0b exp busy=%0b done=%0b",
               cyc, busy, done, exp_busy, exp_done);
    end
  end

  task automatic check_drained(input string name);
    vectors++;
    if (iss_q.size() != 0 || wb_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_drained got pending issues=%0d wbs=%0d exp 0 0", name, iss_q.size(), wb_q.size());
      iss_q.delete(); wb_q.delete();
    end
  endtask

  task automatic test_reset();
    drive_cycle(0, 0, 1);
    drive_cycle(0, 1, 1);
    @(negedge clk); #1;
    vectors++;
    if ({busy, done, dp_valid, dp_first, dp_last, wb_en, wb_group, act_addr, w_addr} !== 12'd0) begin
      miscompares++;
      $display("FAIL reset_outputs got %b exp all zero",
               {busy, done, dp_valid, dp_first, dp_last, wb_en, wb_group, act_addr, w_addr});
    end
`ifdef FC_SEQ_PERF_EN
    vectors++;
    if (stall_cnt !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_stall_cnt got %0d exp 0", stall_cnt);
    end
`endif
    drive_cycle(0, 1, 0);
    drive_cycle(0, 1, 0);
  endtask

  task automatic test_no_stall();
    for (int t = 0; t < 24; t++) begin
      drive_cycle(t == 0, 1, 0);
      if (t == 16) begin
        @(negedge clk); #1;
        vectors++;
        if (busy !== 1'b1 || wb_en !== 1'b1 || wb_group !== 1'b1) begin
          miscompares++;
          $display("FAIL nostall_last_wb got busy=%0b wb_en=%0b group=%0d exp 1 1 1", busy, wb_en, wb_group);
        end
      end
    end
    check_drained("nostall");
  endtask

  task automatic test_stall();
    for (int t = 0; t < 26; t++) begin
      drive_cycle(t == 0, !(t == 2 || t == 3), 0);
      if (t == 2 || t == 3) begin
        @(negedge clk); #1;
        vectors++;
        if (act_addr !== 2'd1 || dp_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL stall_hold t=%0d got act=%0d valid=%0b exp act=1 valid=0", t, act_addr, dp_valid);
        end
      end
      if (t == 19) begin
        @(negedge clk); #1;
        vectors++;
        if (done !== 1'b1) begin
          miscompares++;
          $display("FAIL stall_done got done=%0b exp 1", done);
        end
      end
    end
`ifdef FC_SEQ_PERF_EN
    vectors++;
    if (stall_cnt !== 32'd2) begin
      miscompares++;
      $display("FAIL stall_cnt got %0d exp 2", stall_cnt);
    end
`endif
    check_drained("stall");
  endtask

  task automatic test_ignored_start();
    for (int t = 0; t < 24; t++) begin
      drive_cycle(t == 0 || t == 5 || t == 17, 1, 0);
      if (t == 20) begin
        @(negedge clk); #1;
        vectors++;
        if (busy !== 1'b0 || dp_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL ignored_start_idle got busy=%0b valid=%0b exp 0 0", busy, dp_valid);
        end
      end
    end
    check_drained("ignored_start");
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 42; t++) begin
      drive_cycle(t == 0 || t == 18, 1, 0);
      if (t == 19) begin
        @(negedge clk); #1;
        vectors++;
        if (dp_first !== 1'b1 || act_addr !== 2'd0 || w_addr !== 3'd0) begin
          miscompares++;
          $display("FAIL b2b_restart got first=%0b act=%0d w=%0d exp 1 0 0", dp_first, act_addr, w_addr);
        end
      end
    end
    check_drained("back_to_back");
  endtask

  task automatic test_mid_reset();
    for (int t = 0; t < 36; t++) begin
      drive_cycle(t == 0 || t == 10, 1, t == 6);
      if (t == 6) begin
        @(negedge clk); #1;
        vectors++;
        if ({busy, done, dp_valid, wb_en, act_addr, w_addr} !== 9'd0) begin
          miscompares++;
          $display("FAIL midreset_outputs got %b exp all zero", {busy, done, dp_valid, wb_en, act_addr, w_addr});
        end
      end
      if (t == 27) begin
        @(negedge clk); #1;
        vectors++;
        if (done !== 1'b1) begin
          miscompares++;
          $display("FAIL midreset_rerun_done got done=%0b exp 1", done);
        end
      end
    end
    check_drained("mid_reset");
  endtask

  initial begin
    test_reset();
    test_no_stall();
    test_stall();
    test_ignored_start();
    test_back_to_back();
    test_mid_reset();
    drive_cycle(0, 1, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
